// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences CPU reset and program load, then gates CPU progress
// in free-run, single-step, run-to-breakpoint or cycle-budget mode, and
// generates a periodic acknowledgeable interrupt.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | CPU held in reset, waiting for start
// LOAD   | CPU in reset with program_selector driven, LOAD_CYCLES long
// RUN    | CPU enabled every cycle until a halt condition
// STEP   | CPU enabled for one cycle per accepted step pulse
// HALT   | CPU frozen, waiting for start (reload) or resume
module cpu_run_ctrl #(
  parameter int PC_WIDTH    = 32,
  parameter int SEL_WIDTH   = 2,
  parameter int NUM_BKPT    = 2,
  parameter int CYC_WIDTH   = 32,
  parameter int LOAD_CYCLES = 2
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  input  logic                         start_i,
  input  logic                         resume_i,
  input  logic [SEL_WIDTH-1:0]         prog_sel_i,
  input  logic [1:0]                   mode_i,
  input  logic                         step_i,
  input  logic                         halt_req_i,
  input  logic [NUM_BKPT-1:0]          bkpt_en_i,
  input  logic [NUM_BKPT*PC_WIDTH-1:0] bkpt_addr_i,
  input  logic [CYC_WIDTH-1:0]         budget_i,
  input  logic [CYC_WIDTH-1:0]         irq_period_i,
  input  logic                         irq_ack_i,
  input  logic [PC_WIDTH-1:0]          pc_i,
  output logic                         cpu_reset_o,
  output logic                         cpu_en_o,
  output logic [31:0]                  program_selector_o,
  output logic                         irq_o,
  output logic [2:0]                   state_o,
  output logic                         halted_o,
  output logic [1:0]                   halt_cause_o,
  output logic [CYC_WIDTH-1:0]         cycle_count_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } state_e;

  localparam logic [1:0] MODE_STEP    = 2'd1;
  localparam logic [1:0] MODE_BKPT    = 2'd2;
  localparam logic [1:0] MODE_BUDGET  = 2'd3;
  localparam logic [1:0] CAUSE_REQ    = 2'd0;
  localparam logic [1:0] CAUSE_BKPT   = 2'd1;
  localparam logic [1:0] CAUSE_BUDGET = 2'd2;

  localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [LCW-1:0]         load_cnt_q, load_cnt_d;
  logic [1:0]             cause_q, cause_d;
  logic                   skip_bkpt_q, skip_bkpt_d;
  logic                   step_flag_q, step_flag_d;
  logic                   cpu_reset_q;
  logic                   halted_q;
  logic [31:0]            prog_out_q, prog_out_d;
  logic [SEL_WIDTH:0]     sel_inc;
  logic [CYC_WIDTH-1:0]   cycle_count_q;
  logic [CYC_WIDTH-1:0]   irq_tmr_q, irq_tmr_inc;
  logic                   irq_q;

  logic                   accept_start;
  logic                   clear_cnt;
  logic                   bkpt_hit;
  logic                   halt_bkpt;
  logic                   halt_budget;
  logic                   run_halt;
  logic                   cpu_en;
  logic                   cnt_en;
  logic                   irq_expire;

  // Any enabled comparator whose address equals the current PC.
  always_comb begin
    bkpt_hit = 1'b0;
    for (int i = 0; i < NUM_BKPT; i++) begin
      if (bkpt_en_i[i] && (pc_i == bkpt_addr_i[i*PC_WIDTH +: PC_WIDTH])) begin
        bkpt_hit = 1'b1;
      end
    end
  end

  // The breakpoint check is skipped for one cycle after resume so the CPU can
  // step off the PC it stopped on.
  assign halt_bkpt   = (mode_q == MODE_BKPT) && !skip_bkpt_q && bkpt_hit;
  assign halt_budget = (mode_q == MODE_BUDGET) && (cycle_count_q == budget_i);
  assign run_halt    = halt_req_i || halt_bkpt || halt_budget;

  // CPU enable is combinational so a halting cycle never executes.
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      S_LOAD:  cpu_en = 1'b1;
      S_RUN:   cpu_en = !run_halt;
      S_STEP:  cpu_en = step_flag_q && !halt_req_i;
      default: cpu_en = 1'b0;
    endcase
  end

  assign cnt_en       = cpu_en && !cpu_reset_q;
  assign irq_tmr_inc  = irq_tmr_q + {{(CYC_WIDTH-1){1'b0}}, 1'b1};
  assign irq_expire   = cnt_en && (irq_period_i != '0) && (irq_tmr_inc == irq_period_i);
  assign accept_start = start_i && ((state_q == S_IDLE) || (state_q == S_HALT));

  // Next-state and latched-configuration decode.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sel_d       = sel_q;
    load_cnt_d  = load_cnt_q;
    cause_d     = cause_q;
    skip_bkpt_d = skip_bkpt_q;
    step_flag_d = 1'b0;
    clear_cnt   = 1'b0;
    if (accept_start) begin
      state_d     = S_LOAD;
      mode_d      = mode_i;
      sel_d       = prog_sel_i;
      load_cnt_d  = LOAD_LAST;
      skip_bkpt_d = 1'b0;
      clear_cnt   = 1'b1;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (load_cnt_q == '0) begin
            state_d = (mode_q == MODE_STEP) ? S_STEP : S_RUN;
          end else begin
            load_cnt_d = load_cnt_q - {{(LCW-1){1'b0}}, 1'b1};
          end
        end
        S_RUN: begin
          skip_bkpt_d = 1'b0;
          if (run_halt) begin
            state_d = S_HALT;
            if (halt_req_i)     cause_d = CAUSE_REQ;
            else if (halt_bkpt) cause_d = CAUSE_BKPT;
            else                cause_d = CAUSE_BUDGET;
          end
        end
        S_STEP: begin
          if (halt_req_i) begin
            state_d = S_HALT;
            cause_d = CAUSE_REQ;
          end else begin
            // A step sampled while the CPU is already enabled is dropped.
            step_flag_d = step_i && !cpu_en;
          end
        end
        S_HALT: begin
          if (resume_i && !halt_req_i) begin
            mode_d      = mode_i;
            state_d     = (mode_i == MODE_STEP) ? S_STEP : S_RUN;
            skip_bkpt_d = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign sel_inc    = {1'b0, sel_d} + {{SEL_WIDTH{1'b0}}, 1'b1};
  assign prog_out_d = (state_d == S_LOAD) ? 32'(sel_inc) : 32'd0;

  // FSM state, latched configuration and registered status outputs.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      sel_q       <= '0;
      load_cnt_q  <= '0;
      cause_q     <= CAUSE_REQ;
      skip_bkpt_q <= 1'b0;
      step_flag_q <= 1'b0;
      cpu_reset_q <= 1'b1;
      halted_q    <= 1'b0;
      prog_out_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      load_cnt_q  <= load_cnt_d;
      cause_q     <= cause_d;
      skip_bkpt_q <= skip_bkpt_d;
      step_flag_q <= step_flag_d;
      cpu_reset_q <= (state_d == S_IDLE) || (state_d == S_LOAD);
      halted_q    <= (state_d == S_HALT);
      prog_out_q  <= prog_out_d;
    end
  end

  // Saturating cycle counter, IRQ timer and sticky IRQ flag (frozen in HALT).
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cycle_count_q <= '0;
      irq_tmr_q     <= '0;
      irq_q         <= 1'b0;
    end else begin
      if (clear_cnt) begin
        cycle_count_q <= '0;
        irq_tmr_q     <= '0;
      end else if (cnt_en) begin
        if (cycle_count_q != '1) begin
          cycle_count_q <= cycle_count_q + {{(CYC_WIDTH-1){1'b0}}, 1'b1};
        end
        irq_tmr_q <= irq_expire ? '0 : irq_tmr_inc;
      end
      if (irq_expire) begin
        irq_q <= 1'b1;
      end else if (irq_ack_i && (state_q != S_HALT)) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign cpu_reset_o        = cpu_reset_q;
  assign cpu_en_o           = cpu_en;
  assign program_selector_o = prog_out_q;
  assign irq_o              = irq_q;
  assign state_o            = state_q;
  assign halted_o           = halted_q;
  assign halt_cause_o       = cause_q;
  assign cycle_count_o      = cycle_count_q;

endmodule
